// File: rtl/semaforo_monitor.sv
`default_nettype none
// ============================================================================
// Module   : semaforo_monitor
// Purpose  : Protocol checker for the two traffic-light buses A and B of the
//            semaforo controller. Flags bad one-hot encoding, A/B conflicts,
//            illegal colour order and wrong phase durations. It also records
//            the first violation code, a saturating violation count and the
//            number of completed A green->yellow transitions.
// Revision : 1.0 - initial release
// ============================================================================
module semaforo_monitor #(
  parameter logic [7:0] VERDE    = 8'd1,  // minimum green length
  parameter logic [7:0] AMARELO  = 8'd3,  // exact yellow length
  parameter logic [7:0] VERMELHO = 8'd2   // minimum red length
) (
  input  logic       clk,
  input  logic       rst,       // asynchronous, active low
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] viol_cnt,
  output logic [7:0] ciclos_a
);

  localparam logic [2:0] c_VD       = 3'b001;
  localparam logic [2:0] c_AM       = 3'b010;
  localparam logic [2:0] c_VM       = 3'b100;
  localparam logic [7:0] c_AMA_OVR  = AMARELO + 8'd1;
  localparam logic [7:0] c_DUR_MAX  = 8'hFF;

  // Stage registers: *_q is the newest sample and *_qq the one before it.
  logic [2:0] r_a_q, r_a_qq, r_b_q, r_b_qq;
  // r_smp: *_q holds a real sample; r_vld: *_qq holds a real sample.
  logic       r_smp, r_vld;
  // Duration of the current stage-1 value, plus last cycle's value, which
  // is the length of the phase that has just ended when a change shows up.
  logic [7:0] r_dur_a, r_dur_b, r_pdur_a, r_pdur_b;
  logic       r_first_a, r_first_b;
  // Set once a yellow overrun was reported, so the exit check stays quiet.
  logic       r_ovr_a, r_ovr_b;

  logic       r_err;
  logic [2:0] r_err_code;
  logic [7:0] r_viol_cnt;
  logic [7:0] r_ciclos_a;

  logic       w_ovr_a, w_ovr_b;
  logic [3:0] w_seq_a, w_seq_b;
  logic [7:1] w_viol;
  logic [2:0] w_cand;

  // Transition and duration checks for one light.
  // Bit 0: illegal order, 1: yellow length, 2: green short, 3: red short.
  function automatic logic [3:0] f_seq_viol(
    input logic [2:0] q,
    input logic [2:0] qq,
    input logic       vld,
    input logic       first,
    input logic       ovr,
    input logic       ovr_fire,
    input logic [7:0] pdur
  );
    logic w_chg;
    logic w_legal;
    logic w_dchk;
    // Only changes between two one-hot samples are judged.
    w_chg   = vld && (q != qq) && $onehot(q) && $onehot(qq);
    w_legal = ((qq == c_VD) && (q == c_AM)) ||
              ((qq == c_AM) && (q == c_VM)) ||
              ((qq == c_VM) && (q == c_VD));
    w_dchk  = w_chg && !first;
    f_seq_viol[0] = w_chg && !w_legal;
    f_seq_viol[1] = ovr_fire ||
                    (w_dchk && (qq == c_AM) && !ovr && (pdur != AMARELO));
    f_seq_viol[2] = w_dchk && (qq == c_VD) && (pdur < VERDE);
    f_seq_viol[3] = w_dchk && (qq == c_VM) && (pdur < VERMELHO);
  endfunction

  // Yellow overrun: fires once, in the cycle the count passes AMARELO.
  always_comb begin
    w_ovr_a = (r_a_q == c_AM) && !r_first_a && !r_ovr_a && (r_dur_a == c_AMA_OVR);
    w_ovr_b = (r_b_q == c_AM) && !r_first_b && !r_ovr_b && (r_dur_b == c_AMA_OVR);
    w_seq_a = f_seq_viol(r_a_q, r_a_qq, r_vld, r_first_a, r_ovr_a, w_ovr_a, r_pdur_a);
    w_seq_b = f_seq_viol(r_b_q, r_b_qq, r_vld, r_first_b, r_ovr_b, w_ovr_b, r_pdur_b);
  end

  // Collect all violation codes of this cycle and pick the lowest one.
  always_comb begin
    w_viol[1] = !$onehot(r_a_q);
    w_viol[2] = !$onehot(r_b_q);
    w_viol[3] = (r_a_q != c_VM) && (r_b_q != c_VM);
    w_viol[4] = w_seq_a[0] | w_seq_b[0];
    w_viol[5] = w_seq_a[1] | w_seq_b[1];
    w_viol[6] = w_seq_a[2] | w_seq_b[2];
    w_viol[7] = w_seq_a[3] | w_seq_b[3];
    w_cand    = 3'd0;
    if      (w_viol[1]) w_cand = 3'd1;
    else if (w_viol[2]) w_cand = 3'd2;
    else if (w_viol[3]) w_cand = 3'd3;
    else if (w_viol[4]) w_cand = 3'd4;
    else if (w_viol[5]) w_cand = 3'd5;
    else if (w_viol[6]) w_cand = 3'd6;
    else if (w_viol[7]) w_cand = 3'd7;
  end

  // Sampling pipeline, duration counters and per-phase flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_q     <= c_VM;
      r_a_qq    <= c_VM;
      r_b_q     <= c_VM;
      r_b_qq    <= c_VM;
      r_smp     <= 1'b0;
      r_vld     <= 1'b0;
      r_dur_a   <= 8'd0;
      r_dur_b   <= 8'd0;
      r_pdur_a  <= 8'd0;
      r_pdur_b  <= 8'd0;
      r_first_a <= 1'b1;
      r_first_b <= 1'b1;
      r_ovr_a   <= 1'b0;
      r_ovr_b   <= 1'b0;
    end else begin
      r_a_q    <= A;
      r_a_qq   <= r_a_q;
      r_b_q    <= B;
      r_b_qq   <= r_b_q;
      r_smp    <= 1'b1;
      r_vld    <= r_smp;
      r_pdur_a <= r_dur_a;
      r_pdur_b <= r_dur_b;
      if (A != r_a_q)                r_dur_a <= 8'd1;
      else if (r_dur_a != c_DUR_MAX) r_dur_a <= r_dur_a + 8'd1;
      if (B != r_b_q)                r_dur_b <= 8'd1;
      else if (r_dur_b != c_DUR_MAX) r_dur_b <= r_dur_b + 8'd1;
      if (r_vld && (r_a_q != r_a_qq)) r_first_a <= 1'b0;
      if (r_vld && (r_b_q != r_b_qq)) r_first_b <= 1'b0;
      if (r_a_q != r_a_qq) r_ovr_a <= 1'b0;
      else if (w_ovr_a)    r_ovr_a <= 1'b1;
      if (r_b_q != r_b_qq) r_ovr_b <= 1'b0;
      else if (w_ovr_b)    r_ovr_b <= 1'b1;
    end
  end

  // Error reporting: sticky flag, first code and saturating cycle count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
      r_viol_cnt <= 8'd0;
    end else if (|w_viol) begin
      if (r_viol_cnt != c_DUR_MAX) r_viol_cnt <= r_viol_cnt + 8'd1;
      if (!r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_cand;
      end
    end
  end

  // Count A green->yellow changes, first phase included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ciclos_a <= 8'd0;
    end else if ((r_a_qq == c_VD) && (r_a_q == c_AM)) begin
      r_ciclos_a <= r_ciclos_a + 8'd1;
    end
  end

  assign err      = r_err;
  assign err_code = r_err_code;
  assign viol_cnt = r_viol_cnt;
  assign ciclos_a = r_ciclos_a;

endmodule
`default_nettype wire

// File: tb/tb_semaforo_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_semaforo_monitor
// Purpose  : Directed self-checking bench for semaforo_monitor. A second
//            instance with VERDE=3 exercises the first-phase exemption.
// Revision : 1.0 - initial release
// ============================================================================
module tb_semaforo_monitor;

  logic       clk;
  logic       rst;
  logic [2:0] a_in;
  logic [2:0] b_in;
  logic       err,  err3;
  logic [2:0] code, code3;
  logic [7:0] viol, viol3;
  logic [7:0] cic,  cic3;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] VD = 3'b001;
  localparam logic [2:0] AM = 3'b010;
  localparam logic [2:0] VM = 3'b100;

  semaforo_monitor dut (
    .clk(clk), .rst(rst), .A(a_in), .B(b_in),
    .err(err), .err_code(code), .viol_cnt(viol), .ciclos_a(cic)
  );

  semaforo_monitor #(.VERDE(8'd3)) dut3 (
    .clk(clk), .rst(rst), .A(a_in), .B(b_in),
    .err(err3), .err_code(code3), .viol_cnt(viol3), .ciclos_a(cic3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input pair, let it be sampled, then settle past the edge.
  task automatic step(input logic [2:0] a, input logic [2:0] b);
    a_in = a;
    b_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    a_in = VM;
    b_in = VM;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0d exp=0", err); end
    total++; if (code !== 3'd0) begin bad++; $display("FAIL rst_code got=%0d exp=0", code); end
    total++; if (viol !== 8'd0) begin bad++; $display("FAIL rst_viol got=%0d exp=0", viol); end
    total++; if (cic !== 8'd0) begin bad++; $display("FAIL rst_cic got=%0d exp=0", cic); end
  endtask

  task automatic test_legal();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      step(VD, VM); step(VD, VM);
      step(AM, VM);
      total++; if (cic !== 8'(r)) begin bad++; $display("FAIL legal_cic_pre got=%0d exp=%0d", cic, r); end
      step(AM, VM);
      total++; if (cic !== 8'(r + 1)) begin bad++; $display("FAIL legal_cic_post got=%0d exp=%0d", cic, r + 1); end
      step(AM, VM);
      step(VM, VD); step(VM, AM); step(VM, AM); step(VM, AM);
    end
    step(VM, VM); step(VM, VM);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL legal_err got=%0d exp=0", err); end
    total++; if (viol !== 8'd0) begin bad++; $display("FAIL legal_viol got=%0d exp=0", viol); end
    total++; if (cic !== 8'd3) begin bad++; $display("FAIL legal_cic got=%0d exp=3", cic); end
  endtask

  task automatic test_conflict();
    do_reset();
    step(VD, VD);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL confl_early got=%0d exp=0", err); end
    step(VD, VD);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL confl_err got=%0d exp=1", err); end
    total++; if (code !== 3'd3) begin bad++; $display("FAIL confl_code got=%0d exp=3", code); end
    step(VM, VM);
    total++; if (viol !== 8'd2) begin bad++; $display("FAIL confl_viol got=%0d exp=2", viol); end
  endtask

  task automatic test_illegal();
    do_reset();
    step(VD, VM);
    step(AM, VM); step(AM, VM); step(AM, VM);
    step(VM, VM); step(VM, VM);
    step(VD, VM); step(VD, VM);
    step(VM, VM);                       // green -> red directly
    step(VM, VM);
    total++; if (code !== 3'd4) begin bad++; $display("FAIL illeg_code got=%0d exp=4", code); end
    total++; if (viol !== 8'd1) begin bad++; $display("FAIL illeg_viol1 got=%0d exp=1", viol); end
    step(VD, VM);
    step(AM, VM); step(AM, VM);         // yellow of 2 cycles
    step(VM, VM); step(VM, VM);
    total++; if (code !== 3'd4) begin bad++; $display("FAIL illeg_keep got=%0d exp=4", code); end
    total++; if (viol !== 8'd2) begin bad++; $display("FAIL illeg_viol2 got=%0d exp=2", viol); end
  endtask

  task automatic test_overrun();
    do_reset();
    step(VD, VM);
    step(AM, VM); step(AM, VM); step(AM, VM);
    step(VM, VM); step(VM, VM);
    step(VD, VM);
    step(AM, VM); step(AM, VM); step(AM, VM); step(AM, VM);
    total++; if (viol !== 8'd0) begin bad++; $display("FAIL ovr_early got=%0d exp=0", viol); end
    step(AM, VM);
    total++; if (viol !== 8'd1) begin bad++; $display("FAIL ovr_viol got=%0d exp=1", viol); end
    total++; if (code !== 3'd5) begin bad++; $display("FAIL ovr_code got=%0d exp=5", code); end
    step(VM, VM); step(VM, VM);
    total++; if (viol !== 8'd1) begin bad++; $display("FAIL ovr_exit got=%0d exp=1", viol); end
    step(VD, VM);
    step(AM, VM); step(AM, VM);
    step(VM, VM);
    total++; if (viol !== 8'd1) begin bad++; $display("FAIL short_pre got=%0d exp=1", viol); end
    step(VM, VM);
    total++; if (viol !== 8'd2) begin bad++; $display("FAIL short_viol got=%0d exp=2", viol); end
  endtask

  task automatic test_encoding();
    do_reset();
    step(3'b011, 3'b000);
    step(VM, 3'b000);
    total++; if (code !== 3'd1) begin bad++; $display("FAIL enc_code got=%0d exp=1", code); end
    total++; if (viol !== 8'd1) begin bad++; $display("FAIL enc_viol got=%0d exp=1", viol); end
    for (int i = 3; i <= 261; i++) begin
      step(VM, 3'b000);
      if (i == 255) begin
        total++; if (viol !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", viol); end
      end
      if (i == 256) begin
        total++; if (viol !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", viol); end
      end
    end
    total++; if (viol !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", viol); end
    total++; if (code !== 3'd1) begin bad++; $display("FAIL enc_keep got=%0d exp=1", code); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(3'b011, VM);
    step(VD, VM);
    step(AM, VM); step(AM, VM);
    total++; if (err !== 1'b1 || code !== 3'd1 || viol !== 8'd1 || cic !== 8'd1) begin
      bad++;
      $display("FAIL mid_pre got=%0d/%0d/%0d/%0d exp=1/1/1/1", err, code, viol, cic);
    end
    rst = 1'b0;                         // mid-yellow, off the clock edge
    #1;
    total++; if (err !== 1'b0 || code !== 3'd0 || viol !== 8'd0 || cic !== 8'd0) begin
      bad++;
      $display("FAIL mid_clear got=%0d/%0d/%0d/%0d exp=0/0/0/0", err, code, viol, cic);
    end
    total++; if (err3 !== 1'b0 || code3 !== 3'd0 || viol3 !== 8'd0 || cic3 !== 8'd0) begin
      bad++;
      $display("FAIL mid_clear3 got=%0d/%0d/%0d/%0d exp=0/0/0/0", err3, code3, viol3, cic3);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(VD, VM);                       // 1-cycle first green, exempt
    step(AM, VM); step(AM, VM); step(AM, VM);
    step(VM, VM); step(VM, VM);
    step(VD, VM);
    total++; if (err3 !== 1'b0 || viol3 !== 8'd0) begin
      bad++;
      $display("FAIL first_exempt got=%0d/%0d exp=0/0", err3, viol3);
    end
    step(AM, VM);                       // non-first green of 1 cycle < 3
    step(AM, VM);
    total++; if (code3 !== 3'd6) begin bad++; $display("FAIL green_short got=%0d exp=6", code3); end
    total++; if (cic3 !== 8'd2) begin bad++; $display("FAIL cic3 got=%0d exp=2", cic3); end
  endtask

  initial begin
    rst  = 1'b0;
    a_in = VM;
    b_in = VM;
    test_reset();
    test_legal();
    test_conflict();
    test_illegal();
    test_overrun();
    test_encoding();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/semaforo_monitor.md
# semaforo_monitor

Protocol checker sitting on the far side of the `semaforo` controller outputs. It samples the A and B light buses every cycle and checks that each light uses legal one-hot encoding, follows green→yellow→red→green, and honours the per-state cycle counts. It also checks that the two lights are never open at the same time. It reports the first violation and a saturating violation count, and counts completed A cycles. It is built to be instantiated next to `semaforo` in benches and in the top level.

## Interface

Parameters:
- `VERDE`, 8'd1, minimum green duration in cycles (1..255)
- `AMARELO`, 8'd3, exact yellow duration in cycles (1..254)
- `VERMELHO`, 8'd2, minimum red duration in cycles (1..255)

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-low (asserted when 0).
- `A` input 3: light A state, one-hot; 3'b001 verde, 3'b010 amarelo, 3'b100 vermelho.
- `B` input 3: light B state, same encoding as `A`.
- `err` output 1: sticky; high once any violation has been detected.
- `err_code` output 3: code of the first violation; holds until reset.
- `viol_cnt` output 8: number of cycles with at least one violation; saturates at 255.
- `ciclos_a` output 8: completed A green→yellow transitions; wraps modulo 256.

## Operation

- **Stage 1 register:** `a_q`, `b_q` capture `A` and `B` on each edge.
- **Stage 2 register:** `a_qq`, `b_qq` hold the previous sample. `vld` is cleared by reset, set after the first sample, and gates the transition checks.
- **Duration counters:** `dur_a` and `dur_b` are 8-bit and count consecutive cycles the stage-1 value has been stable.
  - A counter reloads to 1 when its sample changes.
  - It saturates at 255.
- **First-phase exemption:** `first_a` and `first_b` are set by reset and cleared on that light's first change. The phase seen immediately after reset is exempt from duration checks.
- **Violation codes:** evaluated combinationally on the stage registers every cycle.
  - 1: `a_q` not one-hot (includes 3'b000).
  - 2: `b_q` not one-hot.
  - 3: both `a_q` and `b_q` not vermelho (conflict).
  - 4: illegal transition on either light. `a_q` ≠ `a_qq` with `vld` set and not in the legal set (verde→amarelo, amarelo→vermelho, vermelho→verde). Same rule for B.
  - 5: yellow length wrong.
    - On exit from amarelo with `dur` ≠ `AMARELO`.
    - Or overrun: `dur` reaching `AMARELO`+1 while still amarelo. Overrun is flagged once per phase, and the later exit check is suppressed.
  - 6: exit from verde with `dur` < `VERDE`.
  - 7: exit from vermelho with `dur` < `VERMELHO`.
- **Exemptions:**
  - Duration checks (5–7) are skipped when the relevant `first_*` flag is set.
  - Transition and duration checks are skipped for a light whose old or new sample is non-one-hot.
- **Simultaneous violations:** if several codes are active in one cycle, the lowest code is the candidate for `err_code`.
- **Recording a violation:** in any cycle with at least one active code:
  - `viol_cnt` increments by exactly 1.
  - If `err` = 0: `err` ← 1 and `err_code` ← candidate. Later violations never overwrite `err_code`.
- **`ciclos_a`:** increments on every stage-1 change of A from verde to amarelo, including during the first phase.
- **Parameter values:** there is no error path for out-of-range values; the legal ranges are enforced by the bench only.

## Timing

- **Reset values:** while `rst` = 0, asynchronously:
  - `err` = 0, `err_code` = 3'd0, `viol_cnt` = 0, `ciclos_a` = 0.
  - All stage registers = 3'b100, `vld` = 0, `dur_*` = 0, `first_*` = 1.
- **Latency:** an input value present before edge k is sampled at edge k and checked during cycle k.
  - `err`, `err_code` and `viol_cnt` update at edge k+1.
  - Total latency is 2 edges from input to flag.
  - `ciclos_a` follows the same 2-edge latency.
- **Reset mid-operation:** all state clears immediately, and the checker restarts with first-phase exemption. Release of `rst` is synchronised by the bench off the clock edge.
- **Duration count example:** a state held for N cycles yields `dur` = N at its last cycle. For example, yellow held for exactly `AMARELO` cycles passes.
- **Overrun timing:** the overrun flag fires in the cycle where `dur` becomes `AMARELO`+1.

## Test plan

Defaults apply (`VERDE`=1, `AMARELO`=3, `VERMELHO`=2) unless stated.

- **Legal sequence:** A = verde 2, amarelo 3, vermelho 4 cycles, with B vermelho whenever A is not vermelho; repeat 3 times → `err`=0, `viol_cnt`=0, `ciclos_a`=3.
- **Conflict:** A=001 and B=001 for 2 cycles → `err`=1, `err_code`=3, `viol_cnt`=2, with `err` rising 2 edges after the first conflicting sample.
- **Illegal transition and ordering:** A verde→vermelho directly (after a non-first phase) → `err_code`=4. A second violation, yellow of 2 cycles later, leaves `err_code`=4 and gives `viol_cnt`=2.
- **Yellow overrun:** yellow held 5 cycles → exactly one code-5 violation at `dur`=4, with no extra count on exit. A separate yellow of 2 cycles gives code 5 on exit.
- **Encoding priority:** A=3'b011 and B=3'b000 in the same cycle → `err_code`=1, `viol_cnt`=1. Hold B=000 for 254 more cycles → `viol_cnt` saturates at 255.
- **Reset:** pull `rst` low mid-yellow → all outputs 0 immediately. After release, a short first green (1 cycle with `VERDE`=3) is not flagged.
